// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, NOP encoding, reset fetch address
// and the {pc, inst} entry carried through the fetch queue.
package core_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Flush empties the queue and takes
// priority over push and pop; pointers wrap naturally at a power-of-2 depth.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, the imem handshake, the prefetch
// queue feeding decode, and the redirect/misalignment handling.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            ip_clk,
  input  logic            ip_reset,
  output logic [XLEN-1:0] op_inst_addr,
  input  logic            ip_inst_valid,
  input  logic [XLEN-1:0] ip_inst_from_imem,
  input  logic            ip_stall,
  input  logic            ip_redirect_valid,
  input  logic [XLEN-1:0] ip_redirect_pc,
  output logic            op_valid,
  output logic [XLEN-1:0] op_inst,
  output logic [XLEN-1:0] op_pc,
  output logic            op_misaligned
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic             misaligned;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_din;
  fetch_entry_t     q_dout;

  assign op_inst_addr  = fetch_pc;
  assign op_misaligned = misaligned;

  // Pop and push are gated by redirect here so the queue's flush never races them.
  always_comb begin
    op_valid   = (q_count != '0);
    pop        = op_valid && !ip_stall && !ip_redirect_valid;
    push       = ip_inst_valid && !ip_redirect_valid && (!q_full || pop);
    q_din.pc   = fetch_pc;
    q_din.inst = ip_inst_from_imem;
    op_inst    = q_empty ? NOP_INST : q_dout.inst;
    op_pc      = q_empty ? '0       : q_dout.pc;
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (ip_clk),
    .reset (ip_reset),
    .push  (push),
    .pop   (pop),
    .flush (ip_redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      fetch_pc   <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= ip_redirect_valid && (|ip_redirect_pc[1:0]);
      if (ip_redirect_valid)
        fetch_pc <= word_align(ip_redirect_pc);
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model, per-cycle compare on the
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_inst_fetch;
  import core_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        ip_clk = 1'b0;
  logic        ip_reset;
  logic [31:0] op_inst_addr;
  logic        ip_inst_valid;
  logic [31:0] ip_inst_from_imem;
  logic        ip_stall;
  logic        ip_redirect_valid;
  logic [31:0] ip_redirect_pc;
  logic        op_valid;
  logic [31:0] op_inst;
  logic [31:0] op_pc;
  logic        op_misaligned;

  int n_total = 0;
  int n_pass  = 0;

  inst_fetch #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .ip_clk            (ip_clk),
    .ip_reset          (ip_reset),
    .op_inst_addr      (op_inst_addr),
    .ip_inst_valid     (ip_inst_valid),
    .ip_inst_from_imem (ip_inst_from_imem),
    .ip_stall          (ip_stall),
    .ip_redirect_valid (ip_redirect_valid),
    .ip_redirect_pc    (ip_redirect_pc),
    .op_valid          (op_valid),
    .op_inst           (op_inst),
    .op_pc             (op_pc),
    .op_misaligned     (op_misaligned)
  );

  always #5 ip_clk = ~ip_clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h0000_1000 + (a >> 2);
  endfunction

  // Asynchronous imem: word at the presented address.
  assign ip_inst_from_imem = imem_word(op_inst_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents of the prefetch queue and the fetch PC.
  fetch_entry_t m_q[$];
  logic [31:0]  m_pc;
  logic         m_mis;
  bit           model_ok = 0;

  always @(posedge ip_clk) begin
    bit do_pop, do_push;
    fetch_entry_t e;
    if (ip_reset) begin
      m_q.delete();
      m_pc     = RST_PC;
      m_mis    = 1'b0;
      model_ok = 1;
    end else if (ip_redirect_valid) begin
      m_q.delete();
      m_pc  = {ip_redirect_pc[31:2], 2'b00};
      m_mis = (ip_redirect_pc[1:0] != 2'b00);
    end else begin
      m_mis   = 1'b0;
      do_pop  = (m_q.size() != 0) && !ip_stall;
      do_push = ip_inst_valid && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc   = m_pc;
        e.inst = imem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge ip_clk) begin
    if (model_ok) begin
      check("addr", op_inst_addr, m_pc);
      check("misaligned", {31'b0, op_misaligned}, {31'b0, m_mis});
      check("valid", {31'b0, op_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        check("pc", op_pc, m_q[0].pc);
        check("inst", op_inst, m_q[0].inst);
      end else begin
        check("pc_empty", op_pc, 32'h0);
        check("inst_empty", op_inst, NOP_INST);
      end
    end
  end

  task automatic apply(input logic r, input logic iv, input logic st,
                       input logic rv, input logic [31:0] rp);
    ip_reset          = r;
    ip_inst_valid     = iv;
    ip_stall          = st;
    ip_redirect_valid = rv;
    ip_redirect_pc    = rp;
    @(posedge ip_clk);
    #1;
  endtask

  initial begin
    logic [31:0] rp;
    // Reset state
    apply(1, 1, 0, 0, 0);
    check("rst_valid", {31'b0, op_valid}, 32'h0);
    check("rst_addr", op_inst_addr, RST_PC);
    check("rst_inst", op_inst, 32'h0000_0013);
    check("rst_pc", op_pc, 32'h0);
    check("rst_mis", {31'b0, op_misaligned}, 32'h0);

    // Streaming: one instruction per cycle
    for (int k = 1; k <= 5; k++) begin
      apply(0, 1, 0, 0, 0);
      check("stream_pc", op_pc, 32'(4 * (k - 1)));
      check("stream_inst", op_inst, 32'(32'h1000 + k - 1));
      check("stream_addr", op_inst_addr, 32'(4 * k));
    end

    // Stall with pc 4 at head
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    check("pre_stall_pc", op_pc, 32'h4);
    for (int k = 0; k < 4; k++) begin
      apply(0, 1, 1, 0, 0);
      check("stall_pc", op_pc, 32'h4);
      check("stall_addr", op_inst_addr, 32'hC);
    end
    apply(0, 1, 0, 0, 0);
    check("release_pc8", op_pc, 32'h8);
    apply(0, 1, 0, 0, 0);
    check("release_pc12", op_pc, 32'hC);

    // imem not valid: drain, PC holds
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 0, 0);
    check("drain_valid", {31'b0, op_valid}, 32'h0);
    check("drain_inst", op_inst, 32'h0000_0013);
    check("drain_addr", op_inst_addr, 32'h14);
    apply(0, 1, 0, 0, 0);
    check("resume_pc", op_pc, 32'h14);

    // Redirect with two entries queued and stall high
    apply(0, 1, 1, 0, 0);
    apply(0, 1, 1, 1, 32'h200);
    check("redir_valid", {31'b0, op_valid}, 32'h0);
    check("redir_addr", op_inst_addr, 32'h200);
    apply(0, 1, 0, 0, 0);
    check("redir_pc", op_pc, 32'h200);

    // Misaligned redirect
    apply(0, 1, 0, 1, 32'h203);
    check("mis_addr", op_inst_addr, 32'h200);
    check("mis_pulse", {31'b0, op_misaligned}, 32'h1);
    apply(0, 1, 0, 0, 0);
    check("mis_clear", {31'b0, op_misaligned}, 32'h0);
    check("mis_pc", op_pc, 32'h200);

    // PC wrap
    apply(0, 1, 0, 1, 32'hFFFF_FFFC);
    apply(0, 1, 0, 0, 0);
    check("wrap_addr", op_inst_addr, 32'h0);
    check("wrap_pc", op_pc, 32'hFFFF_FFFC);

    // Reset during redirect with a full queue
    apply(0, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0);
    apply(1, 1, 1, 1, 32'h303);
    check("rr_addr", op_inst_addr, RST_PC);
    check("rr_valid", {31'b0, op_valid}, 32'h0);
    check("rr_mis", {31'b0, op_misaligned}, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) rp = 32'($urandom_range(0, 1023));
      else rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      apply(($urandom % 150) == 0, ($urandom % 5) != 0, ($urandom % 4) == 0,
            ($urandom % 16) == 0, rp);
    end
    apply(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
